// File: rtl/cmp_flag_gen.sv
// cmp_flag_gen: digit-serial signed/unsigned magnitude comparator; define CMP_EARLY_EXIT_EN to stop at the first differing digit
module cmp_flag_gen #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic             less_o,
  output logic             equal_o
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic less_q, less_d, equal_q, equal_d, valid_q, valid_d, busy_q, busy_d;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic dig_lt, dig_ne, last, accept;
`ifndef CMP_EARLY_EXIT_EN
  logic found_q, found_d, pend_q, pend_d, eff_found, eff_less;
`endif
  always_comb begin
    a_dig = a_q[idx_q*DIGIT +: DIGIT];
    b_dig = b_q[idx_q*DIGIT +: DIGIT];
    dig_lt = a_dig < b_dig;
    dig_ne = a_dig != b_dig;
    last = idx_q == '0;
    accept = start_i && state_q != SCAN;
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    idx_d = idx_q;
    less_d = less_q;
    equal_d = equal_q;
`ifndef CMP_EARLY_EXIT_EN
    found_d = found_q;
    pend_d = pend_q;
    eff_found = found_q | dig_ne;
    eff_less = found_q ? pend_q : dig_lt;
`endif
    if (accept) begin
      // biasing the sign bit turns a two's-complement compare into an unsigned one
      a_d = src1_i ^ {signed_i, {(WIDTH-1){1'b0}}};
      b_d = src2_i ^ {signed_i, {(WIDTH-1){1'b0}}};
      idx_d = IW'(NDIG - 1);
      state_d = SCAN;
`ifndef CMP_EARLY_EXIT_EN
      found_d = 1'b0;
      pend_d = 1'b0;
`endif
    end else if (state_q == SCAN) begin
`ifdef CMP_EARLY_EXIT_EN
      if (dig_ne || last) begin
        state_d = DONE;
        less_d = dig_lt;
        equal_d = !dig_ne;
      end else begin
        idx_d = idx_q - 1'b1;
      end
`else
      // the first differing digit is remembered; later digits cannot override it
      found_d = eff_found;
      pend_d = eff_less;
      if (last) begin
        state_d = DONE;
        less_d = eff_found & eff_less;
        equal_d = !eff_found;
      end else begin
        idx_d = idx_q - 1'b1;
      end
`endif
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    valid_d = state_d == DONE;
    busy_d = state_d == SCAN;
  end
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      idx_q <= '0;
      less_q <= 1'b0;
      equal_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
      found_q <= 1'b0;
      pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      idx_q <= idx_d;
      less_q <= less_d;
      equal_q <= equal_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
`ifndef CMP_EARLY_EXIT_EN
      found_q <= found_d;
      pend_q <= pend_d;
`endif
    end
  end
  assign busy_o = busy_q;
  assign valid_o = valid_q;
  assign less_o = less_q;
  assign equal_o = equal_q;
endmodule

// File: tb/tb_cmp_flag_gen.sv
// tb_cmp_flag_gen: directed checks of cmp_flag_gen latency, flags, start-while-busy, reset abort and back-to-back
module tb_cmp_flag_gen;
`ifdef CMP_EARLY_EXIT_EN
  localparam int KE1 = 1;
`else
  localparam int KE1 = 8;
`endif
  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic signed_i = 1'b0;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;
  logic busy_o, valid_o, less_o, equal_o;
  int n_cmp = 0;
  int n_err = 0;
  logic exp_less = 1'b0;
  logic exp_eq = 1'b0;
  int n, pulses;

  cmp_flag_gen #(.WIDTH(32), .DIGIT(4)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .signed_i(signed_i),
    .src1_i(src1_i), .src2_i(src2_i),
    .busy_o(busy_o), .valid_o(valid_o), .less_o(less_o), .equal_o(equal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!valid_o && cnt < 40);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int k, input logic l, input logic e);
    int cnt;
    src1_i = a;
    src2_i = b;
    signed_i = s;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk({tag, "_busy_E"}, busy_o, 1'b1);
    chk({tag, "_hold_less"}, less_o, exp_less);
    chk({tag, "_hold_eq"}, equal_o, exp_eq);
    wait_valid(cnt);
    chk({tag, "_latency"}, cnt, k);
    chk({tag, "_less"}, less_o, l);
    chk({tag, "_equal"}, equal_o, e);
    chk({tag, "_busy_done"}, busy_o, 1'b0);
    exp_less = l;
    exp_eq = e;
    step();
    chk({tag, "_pulse_end"}, valid_o, 1'b0);
    chk({tag, "_flags_hold"}, {less_o, equal_o}, {l, e});
  endtask

  initial begin
    #12;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_less", less_o, 1'b0);
    chk("rst_equal", equal_o, 1'b0);
    @(negedge clk_i);
    rst_n = 1'b1;
    step();
    run_op("t1_late", 32'h0000_0005, 32'h0000_0007, 1'b0, 8, 1'b1, 1'b0);
    run_op("t2_signed", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, KE1, 1'b1, 1'b0);
    run_op("t2_unsigned", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, KE1, 1'b0, 1'b0);
    run_op("t3_eq", 32'h1234_5678, 32'h1234_5678, 1'b1, 8, 1'b0, 1'b1);
    run_op("t3_zero", 32'h0, 32'h0, 1'b1, 8, 1'b0, 1'b1);
    // reset mid-scan
    src1_i = 32'hAAAA_AAAA;
    src2_i = 32'hAAAA_AAAA;
    signed_i = 1'b0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    chk("t5_busy_mid", busy_o, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy_o, 1'b0);
    chk("t5_rst_valid", valid_o, 1'b0);
    chk("t5_rst_less", less_o, 1'b0);
    chk("t5_rst_equal", equal_o, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (valid_o) pulses++;
    end
    chk("t5_no_valid", pulses, 0);
    exp_less = 1'b0;
    exp_eq = 1'b0;
    run_op("t5_after", 32'h3, 32'h2, 1'b0, 8, 1'b0, 1'b0);
    // start while busy is ignored
    src1_i = 32'h8000_0000;
    src2_i = 32'h0;
    signed_i = 1'b0;
    start_i = 1'b1;
    step();
    src1_i = 32'h0;
    src2_i = 32'h1;
    step();
    start_i = 1'b0;
    n = 1;
    while (!valid_o && n < 40) begin
      step();
      n++;
    end
    chk("t4_latency", n, KE1);
    chk("t4_less", less_o, 1'b0);
    chk("t4_equal", equal_o, 1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (valid_o) pulses++;
    end
    chk("t4_no_second", pulses, 0);
    chk("t4_idle", busy_o, 1'b0);
    // back-to-back through the DONE cycle
    src1_i = 32'h1;
    src2_i = 32'h2;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    wait_valid(n);
    chk("t6a_latency", n, 8);
    chk("t6a_less", less_o, 1'b1);
    chk("t6a_equal", equal_o, 1'b0);
    src1_i = 32'h1000_0000;
    src2_i = 32'h0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("t6b_busy_no_bubble", busy_o, 1'b1);
    chk("t6b_valid_low", valid_o, 1'b0);
    chk("t6b_flags_kept", {less_o, equal_o}, 2'b10);
    wait_valid(n);
    chk("t6b_latency", n, KE1);
    chk("t6b_less", less_o, 1'b0);
    chk("t6b_equal", equal_o, 1'b0);
    step();
    chk("t6b_pulse_end", valid_o, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
